// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception codes and bit positions shared by the
// exception unit, the E/M pipeline register and the PC mux.
package cp0_pkg;
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] CP0_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] CP0_PRID_VAL   = 32'h2022_0007;

    // A delay-slot victim is restarted at its branch so the branch re-executes.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] p;
        p = bd ? pc - 32'd4 : pc;
        return {p[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/cp0_exc_unit_if.sv
// cp0_exc_unit_if: M-stage connection between the pipeline and the CP0 exception unit.
interface cp0_exc_unit_if;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
    logic        req;

    modport master (
        output we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
        input  cp0_rdata, epc_out, handler_pc, req
    );
    modport slave (
        input  we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, exl_clr,
        output cp0_rdata, epc_out, handler_pc, req
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: M-stage CP0 holding SR/Cause/EPC; decides exceptions/interrupts and
// serves mtc0, mfc0 and eret.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = CP0_HANDLER_PC,
    parameter logic [31:0] PRID_VAL   = CP0_PRID_VAL
) (
    input logic           clk,
    input logic           reset,
    cp0_exc_unit_if.slave bus
);
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [4:0]  code;
    logic        sr_wr;
    logic        epc_wr;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (bus.exc_code_in != EXC_INT) & ~sr_exl;
    assign req     = int_req | exc_req;
    assign code    = int_req ? EXC_INT : bus.exc_code_in;
    assign sr_wr   = bus.we & (bus.cp0_addr == CP0_SR);
    assign epc_wr  = bus.we & (bus.cp0_addr == CP0_EPC);

    assign sr_val    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

    // eret beats an SR write on EXL only; IM/IE still take the written value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im  <= '0;
            sr_exl <= 1'b0;
            sr_ie  <= 1'b0;
        end else if (req) begin
            sr_exl <= 1'b1;
        end else begin
            if (sr_wr) begin
                sr_im <= bus.cp0_wdata[SR_IM_HI:SR_IM_LO];
                sr_ie <= bus.cp0_wdata[SR_IE];
            end
            if (bus.exl_clr)
                sr_exl <= 1'b0;
            else if (sr_wr)
                sr_exl <= bus.cp0_wdata[SR_EXL];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
        end else begin
            cause_ip <= bus.hw_int;
            if (req) begin
                cause_bd  <= bus.bd_in;
                cause_exc <= code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            epc <= '0;
        else if (req)
            epc <= victim_epc(bus.vpc, bus.bd_in);
        else if (epc_wr)
            epc <= {bus.cp0_wdata[31:2], 2'b00};
    end

    always_comb begin
        bus.cp0_rdata = '0;
        bus.cp0_rdata = bus.cp0_addr == CP0_SR    ? sr_val    :
                        bus.cp0_addr == CP0_CAUSE ? cause_val :
                        bus.cp0_addr == CP0_EPC   ? epc       :
                        bus.cp0_addr == CP0_PRID  ? PRID_VAL  : 32'd0;
    end

    assign bus.req        = req;
    assign bus.epc_out    = epc;
    assign bus.handler_pc = HANDLER_PC;
endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed scenarios plus randomized traffic checked against a
// word-level model of SR, Cause and EPC.
module tb_cp0_exc_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_exc_unit_if b ();
    cp0_exc_unit dut (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    function automatic logic m_int();
        return (|(b.hw_int & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() | ((b.exc_code_in != 5'd0) & ~m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2022_0007;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        b.we = 1'b0; b.cp0_addr = 5'd0; b.cp0_wdata = 32'd0; b.vpc = 32'd0;
        b.bd_in = 1'b0; b.exc_code_in = 5'd0; b.hw_int = 6'd0; b.exl_clr = 1'b0;
    endtask

    // Advance one clock, applying the architectural rules to the model words.
    task automatic tick();
        logic [31:0] s, c, e;
        s = m_sr; e = m_epc;
        c = (m_cause & ~32'h0000_FC00) | ({26'd0, b.hw_int} << 10);
        if (m_req()) begin
            s = s | 32'd2;
            c = {b.bd_in, c[30:7], m_int() ? 5'd0 : b.exc_code_in, 2'b00};
            e = (b.vpc - (b.bd_in ? 32'd4 : 32'd0)) & ~32'd3;
        end else begin
            if (b.we && b.cp0_addr == 5'd12) s = b.cp0_wdata & 32'h0000_FC03;
            if (b.exl_clr) s = s & ~32'd2;
            if (b.we && b.cp0_addr == 5'd14) e = b.cp0_wdata & ~32'd3;
        end
        if (!reset) begin s = 0; c = 0; e = 0; end
        @(posedge clk);
        #1;
        m_sr = s; m_cause = c; m_epc = e;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        b.cp0_addr = a;
        #1;
        d = b.cp0_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        idle();
        b.exc_code_in = 5'd12;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        b.exc_code_in = 5'd0;
        for (int i = 12; i <= 14; i++) begin
            rd(5'(i), d);
            n_cmp++;
            if (d !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d got %h want 00000000", i, d); end
        end
        n_cmp++;
        if (b.req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", b.req); end
        rd(5'd15, d);
        n_cmp++;
        if (d !== 32'h2022_0007) begin n_bad++; $display("FAIL reset_prid got %h want 20220007", d); end
        n_cmp++;
        if (b.handler_pc !== 32'h0000_4180) begin n_bad++; $display("FAIL handler_pc got %h want 00004180", b.handler_pc); end
    endtask

    task automatic test_ov_delay_slot();
        logic [31:0] d;
        b.exc_code_in = 5'd12; b.bd_in = 1'b1; b.vpc = 32'h3010;
        #1;
        n_cmp++;
        if (b.req !== 1'b1) begin n_bad++; $display("FAIL ov_req got %b want 1", b.req); end
        tick();
        idle();
        rd(5'd14, d);
        n_cmp++;
        if (d !== 32'h300C) begin n_bad++; $display("FAIL ov_epc got %h want 0000300c", d); end
        rd(5'd13, d);
        n_cmp++;
        if (d !== 32'h8000_0030) begin n_bad++; $display("FAIL ov_cause got %h want 80000030", d); end
        rd(5'd12, d);
        n_cmp++;
        if (d[1] !== 1'b1) begin n_bad++; $display("FAIL ov_exl got %b want 1", d[1]); end
        n_cmp++;
        if (b.epc_out !== 32'h300C) begin n_bad++; $display("FAIL ov_epc_out got %h want 0000300c", b.epc_out); end
    endtask

    task automatic test_masking();
        logic [31:0] d;
        b.exc_code_in = 5'd4; b.hw_int = 6'b100000;
        #1;
        n_cmp++;
        if (b.req !== 1'b0) begin n_bad++; $display("FAIL mask_exl_req got %b want 0", b.req); end
        tick();
        rd(5'd13, d);
        n_cmp++;
        if (d[15:10] !== 6'b100000) begin n_bad++; $display("FAIL mask_ip_track got %b want 100000", d[15:10]); end
        idle();
        b.exl_clr = 1'b1;
        tick();
        b.exl_clr = 1'b0;
        b.exc_code_in = 5'd4; b.bd_in = 1'b1; b.vpc = 32'd0;
        #1;
        n_cmp++;
        if (b.req !== 1'b1) begin n_bad++; $display("FAIL mask_unmasked_req got %b want 1", b.req); end
        tick();
        idle();
        rd(5'd14, d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL mask_epc_wrap got %h want fffffffc", d); end
        b.exl_clr = 1'b1;
        tick();
        b.exl_clr = 1'b0;
    endtask

    task automatic test_int_priority();
        logic [31:0] d;
        b.we = 1'b1; b.cp0_addr = 5'd12; b.cp0_wdata = 32'h0000_0401;
        tick();
        idle();
        b.hw_int = 6'b000001; b.exc_code_in = 5'd10; b.vpc = 32'h5000;
        #1;
        n_cmp++;
        if (b.req !== 1'b1) begin n_bad++; $display("FAIL int_req got %b want 1", b.req); end
        tick();
        b.hw_int = 6'd0; b.exc_code_in = 5'd0;
        rd(5'd13, d);
        n_cmp++;
        if (d[6:2] !== 5'd0) begin n_bad++; $display("FAIL int_code got %0d want 0", d[6:2]); end
        rd(5'd14, d);
        n_cmp++;
        if (d !== 32'h5000) begin n_bad++; $display("FAIL int_epc got %h want 00005000", d); end
        b.exl_clr = 1'b1;
        tick();
        b.exl_clr = 1'b0;
    endtask

    task automatic test_write_rules();
        logic [31:0] old, d;
        rd(5'd13, old);
        b.we = 1'b1; b.cp0_addr = 5'd13; b.cp0_wdata = 32'hFFFF_FFFF;
        tick();
        b.we = 1'b0;
        rd(5'd13, d);
        n_cmp++;
        if (d !== old) begin n_bad++; $display("FAIL wr_cause_ignored got %h want %h", d, old); end
        b.we = 1'b1; b.cp0_addr = 5'd14; b.cp0_wdata = 32'h3007;
        tick();
        b.we = 1'b0;
        rd(5'd14, d);
        n_cmp++;
        if (d !== 32'h3004) begin n_bad++; $display("FAIL wr_epc got %h want 00003004", d); end
        b.we = 1'b1; b.cp0_addr = 5'd12; b.cp0_wdata = 32'd0;
        b.exc_code_in = 5'd8; b.vpc = 32'h6000;
        tick();
        idle();
        rd(5'd12, d);
        n_cmp++;
        if (d !== 32'h0000_0403) begin n_bad++; $display("FAIL wr_sr_vs_req got %h want 00000403", d); end
        b.exl_clr = 1'b1;
        tick();
        b.exl_clr = 1'b0;
    endtask

    task automatic test_same_cycle_read();
        logic [31:0] old, d;
        rd(5'd14, old);
        b.we = 1'b1; b.cp0_wdata = 32'h4000;
        rd(5'd14, d);
        n_cmp++;
        if (d !== 32'h6000 || old !== 32'h6000) begin n_bad++; $display("FAIL same_cycle_old got %h want 00006000", d); end
        tick();
        b.we = 1'b0;
        rd(5'd14, d);
        n_cmp++;
        if (d !== 32'h4000) begin n_bad++; $display("FAIL same_cycle_new got %h want 00004000", d); end
    endtask

    task automatic test_reset_mid_handler();
        logic [31:0] d;
        b.exc_code_in = 5'd5;
        tick();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rd(5'd12, d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL reset_mid_handler_sr got %h want 00000000", d); end
    endtask

    task automatic test_random();
        logic [4:0] codes [8] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(31) != 0);
            b.we = ($urandom_range(2) == 0);
            b.cp0_addr = 5'($urandom_range(16, 10));
            b.cp0_wdata = $urandom;
            b.vpc = $urandom;
            b.bd_in = 1'($urandom);
            b.exc_code_in = codes[$urandom_range(7)];
            b.hw_int = ($urandom_range(2) == 0) ? 6'($urandom) : 6'd0;
            b.exl_clr = ($urandom_range(3) == 0);
            #1;
            n_cmp++;
            if (b.req !== m_req()) begin n_bad++; $display("FAIL rand_req[%0d] got %b want %b", i, b.req, m_req()); end
            n_cmp++;
            if (b.cp0_rdata !== m_read(b.cp0_addr)) begin
                n_bad++; $display("FAIL rand_rdata[%0d] addr %0d got %h want %h", i, b.cp0_addr, b.cp0_rdata, m_read(b.cp0_addr));
            end
            n_cmp++;
            if (b.epc_out !== m_epc) begin n_bad++; $display("FAIL rand_epc_out[%0d] got %h want %h", i, b.epc_out, m_epc); end
            tick();
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_ov_delay_slot();
        test_masking();
        test_int_priority();
        test_write_rules();
        test_same_cycle_read();
        test_reset_mid_handler();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
